// File: rtl/nx_node_store_arb_pkg.sv
// rtl/nx_node_store_arb_pkg.sv - shared types and helpers for the node store port-A arbiter
package nx_node_store_arb_pkg;

  typedef enum logic [1:0] {
    NX_STORE_GRANT_IDLE  = 2'd0,
    NX_STORE_GRANT_READ  = 2'd1,
    NX_STORE_GRANT_WRITE = 2'd2
  } nx_store_grant_t;

  typedef enum logic [0:0] {
    NX_STORE_ARB_READ_PRIO = 1'b0,
    NX_STORE_ARB_DRAIN     = 1'b1
  } nx_store_arb_mode_t;

  localparam int NX_STORE_STALL_CNT_W = 16;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int nx_store_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nx_node_store_arb_if.sv
// rtl/nx_node_store_arb_if.sv - decoder/core/port-A signal bundle (NX_NODE_STORE_ARB_STATS_EN adds o_stall_count)
interface nx_node_store_arb_if #(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32
);
  logic [RAM_ADDR_W-1:0] i_wr_addr;
  logic [RAM_DATA_W-1:0] i_wr_data;
  logic                  i_wr_valid;
  logic                  o_wr_ready;
  logic [RAM_ADDR_W-1:0] i_rd_addr;
  logic                  i_rd_en;
  logic                  o_rd_stall;
  logic [RAM_DATA_W-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic [RAM_ADDR_W-1:0] o_ram_addr;
  logic [RAM_DATA_W-1:0] o_ram_wr_data;
  logic                  o_ram_wr_en;
  logic                  o_ram_en;
  logic [RAM_DATA_W-1:0] i_ram_rd_data;
`ifdef NX_NODE_STORE_ARB_STATS_EN
  logic [15:0]           o_stall_count;
`endif

  modport master (
    output i_wr_addr, i_wr_data, i_wr_valid, i_rd_addr, i_rd_en, i_ram_rd_data,
    input  o_wr_ready, o_rd_stall, o_rd_data, o_rd_valid,
           o_ram_addr, o_ram_wr_data, o_ram_wr_en, o_ram_en
`ifdef NX_NODE_STORE_ARB_STATS_EN
    , input o_stall_count
`endif
  );

  modport slave (
    input  i_wr_addr, i_wr_data, i_wr_valid, i_rd_addr, i_rd_en, i_ram_rd_data,
    output o_wr_ready, o_rd_stall, o_rd_data, o_rd_valid,
           o_ram_addr, o_ram_wr_data, o_ram_wr_en, o_ram_en
`ifdef NX_NODE_STORE_ARB_STATS_EN
    , output o_stall_count
`endif
  );

endinterface

// File: rtl/nx_node_store_wr_fifo.sv
// rtl/nx_node_store_wr_fifo.sv - decoder write buffer with head, level flags and address hit
module nx_node_store_wr_fifo
  import nx_node_store_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = nx_store_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              hit
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_nxt;
  logic [DEPTH-1:0]  match;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Slot occupancy: a pop frees the head slot, a push claims the tail (push wins on a shared slot).
  always_comb begin
    valid_nxt = valid_q;
    if (do_pop)  valid_nxt[rd_ptr] = 1'b0;
    if (do_push) valid_nxt[wr_ptr] = 1'b1;
  end

  // Per-entry address compare against the fetch address, only for occupied slots.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (addr_mem[i] == cmp_addr);
    end
  end

  assign hit = |match;

  // Entry storage; contents of free slots are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy count and slot-valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      valid_q <= valid_nxt;
    end
  end

endmodule

// File: rtl/nx_node_store_arb.sv
// rtl/nx_node_store_arb.sv - port-A arbiter between decoder writes and core fetch (option: NX_NODE_STORE_ARB_STATS_EN)
module nx_node_store_arb
  import nx_node_store_arb_pkg::*;
#(
  parameter int RAM_ADDR_W    = 10,
  parameter int RAM_DATA_W    = 32,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input logic               i_clk,
  input logic               i_rst,
  nx_node_store_arb_if.slave bus
);
  localparam int CNT_W = nx_store_cnt_w(WR_FIFO_DEPTH);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] MODE_READ_PRIO = NX_STORE_ARB_READ_PRIO;
  localparam logic [0:0] MODE_DRAIN     = NX_STORE_ARB_DRAIN;

  nx_store_grant_t   grant;
  logic [0:0]        mode_q;
  logic [0:0]        mode_nxt;
  logic [STV_W-1:0]  starve_q;
  logic              starve_at_limit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_nxt;
  logic              fifo_hit;
  logic              raw_hit;
  logic              drain_trig;
  logic              drain_now;
  logic              push;
  logic              pop;
  logic              rd_valid_q;
  logic [RAM_ADDR_W-1:0] head_addr;
  logic [RAM_DATA_W-1:0] head_data;

  nx_node_store_wr_fifo #(
    .DEPTH  (WR_FIFO_DEPTH),
    .ADDR_W (RAM_ADDR_W),
    .DATA_W (RAM_DATA_W),
    .CNT_W  (CNT_W)
  ) u_wr_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_addr (bus.i_wr_addr),
    .push_data (bus.i_wr_data),
    .pop       (pop),
    .cmp_addr  (bus.i_rd_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .hit       (fifo_hit)
  );

  // Ready never depends on this cycle's pop, only on occupancy and reset.
  assign bus.o_wr_ready = !i_rst && !fifo_full;
  assign push           = bus.i_wr_valid && bus.o_wr_ready;
  assign pop            = (grant == NX_STORE_GRANT_WRITE);
  assign count_nxt      = fifo_count + CNT_W'(push) - CNT_W'(pop);

  assign raw_hit         = bus.i_rd_en && fifo_hit;
  assign starve_at_limit = (starve_q == STV_W'(STARVE_LIMIT));
  // A full buffer or an exhausted starvation budget forces writes from this very cycle.
  assign drain_trig      = fifo_full || (starve_at_limit && !fifo_empty);
  assign drain_now       = (mode_q == MODE_DRAIN) || drain_trig;

  // Per-cycle grant, highest priority first: RAW hazard, drain, fetch, opportunistic write.
  always_comb begin
    grant = NX_STORE_GRANT_IDLE;
    if (i_rst)                         grant = NX_STORE_GRANT_IDLE;
    else if (raw_hit)                  grant = NX_STORE_GRANT_WRITE;
    else if (drain_now && !fifo_empty) grant = NX_STORE_GRANT_WRITE;
    else if (bus.i_rd_en)              grant = NX_STORE_GRANT_READ;
    else if (!fifo_empty)              grant = NX_STORE_GRANT_WRITE;
  end

  // Mode: enter drain on a trigger unless this cycle already empties the buffer; leave when empty.
  always_comb begin
    mode_nxt = mode_q;
    if (mode_q == MODE_READ_PRIO) begin
      if (drain_trig && (count_nxt != '0)) mode_nxt = MODE_DRAIN;
    end else if (count_nxt == '0) begin
      mode_nxt = MODE_READ_PRIO;
    end
  end

  // Mode register.
  always_ff @(posedge i_clk) begin
    if (i_rst) mode_q <= MODE_READ_PRIO;
    else       mode_q <= mode_nxt;
  end

  // Consecutive cycles a pending write has lost port A, saturating at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst || fifo_empty || pop) starve_q <= '0;
    else if (!starve_at_limit)      starve_q <= starve_q + STV_W'(1);
  end

  // Read data returns one cycle after the grant, straight from the RAM output.
  always_ff @(posedge i_clk) begin
    if (i_rst) rd_valid_q <= 1'b0;
    else       rd_valid_q <= (grant == NX_STORE_GRANT_READ);
  end

  assign bus.o_rd_valid    = rd_valid_q && !i_rst;
  assign bus.o_rd_data     = bus.i_ram_rd_data;
  assign bus.o_rd_stall    = i_rst || (bus.i_rd_en && (grant != NX_STORE_GRANT_READ));
  assign bus.o_ram_en      = (grant != NX_STORE_GRANT_IDLE);
  assign bus.o_ram_wr_en   = (grant == NX_STORE_GRANT_WRITE);
  assign bus.o_ram_addr    = (grant == NX_STORE_GRANT_WRITE) ? head_addr : bus.i_rd_addr;
  assign bus.o_ram_wr_data = head_data;

`ifdef NX_NODE_STORE_ARB_STATS_EN
  logic [NX_STORE_STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled fetch cycles outside reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) stall_cnt_q <= '0;
    else if (bus.o_rd_stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + NX_STORE_STALL_CNT_W'(1);
  end

  assign bus.o_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nx_node_store_arb.sv
// tb/tb_nx_node_store_arb.sv - randomized and directed checks against a queue-based reference model
module tb_nx_node_store_arb;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 3;
  localparam int G_IDLE = 0, G_READ = 1, G_WRITE = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nx_node_store_arb_if #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW)) bus();

  nx_node_store_arb #(
    .RAM_ADDR_W    (AW),
    .RAM_DATA_W    (DW),
    .WR_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT  (LIM)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_q = '0;

  always @(posedge clk) begin
    if (bus.o_ram_en && bus.o_ram_wr_en) ram[bus.o_ram_addr] <= bus.o_ram_wr_data;
    else if (bus.o_ram_en)               ram_q <= ram[bus.o_ram_addr];
  end
  assign bus.i_ram_rd_data = ram_q;

  ent_t          q[$];
  bit            draining;
  int            starve;
  bit            exp_valid;
  logic [DW-1:0] exp_data;
  int            exp_stall;
  logic [DW-1:0] arch      [0:1023];
  logic [DW-1:0] committed [0:1023];
  bit            prev_rd_stalled, prev_wr_blocked;

  int compared   = 0;
  int mismatched = 0;
  int wr_seen, stall_seen, rd_before_wr;
  bit seen_write;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_cycle();
    int            g;
    int            sz0;
    bit            hz, fd, acc, stl;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    #1;
    sz0 = q.size();
    ra  = bus.i_rd_addr;
    wa  = bus.i_wr_addr;
    wd  = bus.i_wr_data;
    hz  = 1'b0;
    if (bus.i_rd_en) foreach (q[i]) if (q[i].a == ra) hz = 1'b1;
    fd = draining || (sz0 == DEPTH) || (starve == LIM && sz0 > 0);
    if (rst)                  g = G_IDLE;
    else if (hz)              g = G_WRITE;
    else if (fd && sz0 > 0)   g = G_WRITE;
    else if (bus.i_rd_en)     g = G_READ;
    else if (sz0 > 0)         g = G_WRITE;
    else                      g = G_IDLE;
    stl = rst || (bus.i_rd_en && g != G_READ);

    check_eq("wr_ready", bus.o_wr_ready, !rst && sz0 < DEPTH);
    check_eq("rd_stall", bus.o_rd_stall, stl);
    check_eq("ram_en", bus.o_ram_en, g != G_IDLE);
    check_eq("ram_wr_en", bus.o_ram_wr_en, g == G_WRITE);
    if (g == G_WRITE) begin
      check_eq("wr_addr", bus.o_ram_addr, q[0].a);
      check_eq("wr_data", bus.o_ram_wr_data, q[0].d);
    end
    if (g == G_READ) check_eq("rd_addr", bus.o_ram_addr, ra);
    check_eq("rd_valid", bus.o_rd_valid, exp_valid && !rst);
    if (exp_valid && !rst) check_eq("rd_data", bus.o_rd_data, exp_data);
`ifdef NX_NODE_STORE_ARB_STATS_EN
    check_eq("stall_count", bus.o_stall_count, exp_stall);
`endif

    if (bus.o_ram_en && bus.o_ram_wr_en) begin wr_seen++; seen_write = 1'b1; end
    if (bus.o_ram_en && !bus.o_ram_wr_en && !seen_write) rd_before_wr++;
    if (bus.o_rd_stall && !rst) stall_seen++;

    acc = !rst && bus.i_wr_valid && sz0 < DEPTH;
    prev_rd_stalled = bus.i_rd_en && stl;
    prev_wr_blocked = bus.i_wr_valid && !acc;

    @(posedge clk);
    if (rst) begin
      q.delete();
      draining  = 1'b0;
      starve    = 0;
      exp_valid = 1'b0;
      exp_stall = 0;
      arch      = committed;
    end else begin
      exp_valid = (g == G_READ);
      if (g == G_READ) exp_data = arch[ra];
      if (!draining && (sz0 == DEPTH || (starve == LIM && sz0 > 0))) draining = 1'b1;
      starve = (sz0 == 0 || g == G_WRITE) ? 0 : ((starve < LIM) ? starve + 1 : LIM);
      if (g == G_WRITE) begin
        committed[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back('{a: wa, d: wd});
        arch[wa] = wd;
      end
      if (q.size() == 0) draining = 1'b0;
      if (stl && exp_stall != 16'hFFFF) exp_stall++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_rd_en    = 1'b0;
    bus.i_rd_addr  = '0;
  endtask

  task automatic set_write(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_wr_valid = v;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
  endtask

  task automatic zero_counters();
    wr_seen = 0; stall_seen = 0; rd_before_wr = 0; seen_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0; arch[i] = '0; committed[i] = '0;
    end
    draining = 1'b0; starve = 0; exp_valid = 1'b0; exp_data = '0; exp_stall = 0;
    prev_rd_stalled = 1'b0; prev_wr_blocked = 1'b0;
    zero_counters();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset state, including a fetch request held during reset.
    run_cycle();
    bus.i_rd_en = 1'b1;
    run_cycle();
    rst = 1'b0;
    clear_inputs();
    run_cycle();

    // Write-only burst: four consecutive port-A writes.
    zero_counters();
    for (int i = 0; i < 4; i++) begin
      set_write(1'b1, AW'(10'h010 + i), DW'(32'hA0 + i));
      run_cycle();
    end
    set_write(1'b0, '0, '0);
    repeat (4) run_cycle();
    check_eq("wronly_writes", wr_seen, 4);

    // Starvation: one pending write waits out three read grants.
    bus.i_rd_en = 1'b1;
    bus.i_rd_addr = AW'(10'h100);
    set_write(1'b1, AW'(10'h040), 32'h0000_1234);
    run_cycle();
    set_write(1'b0, '0, '0);
    zero_counters();
    repeat (7) run_cycle();
    check_eq("starve_reads", rd_before_wr, 3);
    check_eq("starve_stalls", stall_seen, 1);

    // Full buffer under continuous fetch.
    zero_counters();
    for (int i = 0; i < 4; i++) begin
      set_write(1'b1, AW'(10'h050 + i), DW'(32'hB0 + i));
      run_cycle();
    end
    set_write(1'b0, '0, '0);
    repeat (8) run_cycle();
    check_eq("full_writes", wr_seen, 4);
    check_eq("full_stalls", stall_seen, 4);

    // RAW hazard: fetch of a buffered address waits for the write.
    set_write(1'b1, AW'(10'h020), 32'h0000_DEAD);
    run_cycle();
    set_write(1'b0, '0, '0);
    bus.i_rd_addr = AW'(10'h020);
    repeat (4) run_cycle();

    // Same-cycle ordering: read granted with a same-address accept sees old data.
    bus.i_rd_en = 1'b0;
    repeat (2) run_cycle();
    bus.i_rd_en = 1'b1;
    bus.i_rd_addr = AW'(10'h030);
    set_write(1'b1, AW'(10'h030), 32'h0000_0055);
    run_cycle();
    set_write(1'b0, '0, '0);
    repeat (4) run_cycle();

    // Reset while draining three buffered writes.
    bus.i_rd_addr = AW'(10'h100);
    for (int i = 0; i < 3; i++) begin
      set_write(1'b1, AW'(10'h060 + i), DW'(32'hC0 + i));
      run_cycle();
    end
    set_write(1'b0, '0, '0);
    repeat (2) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    zero_counters();
    repeat (5) run_cycle();
    check_eq("rst_drain_writes", wr_seen, 0);

    // Randomized traffic with occasional resets; requesters hold while stalled.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!prev_rd_stalled) begin
        bus.i_rd_en   = ($urandom_range(0, 3) != 0);
        bus.i_rd_addr = AW'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? AW'(10'h100) : AW'(0));
      end
      if (!prev_wr_blocked) begin
        set_write($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), DW'($urandom));
      end
      run_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    repeat (8) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
